uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- UART receiver that sits directly downstream of the baud tick generator. The generator runs with Oversampling = OVERSAMPLE and drives this block's tick input.
- Synchronises the asynchronous serial line and detects a valid start bit. Samples each bit at its centre using the oversample ticks.
- Presents each received byte with a one-clock valid strobe, and reports stop-bit framing errors.
- The received byte and strobe feed the lab's byte-consumer logic (display/echo path).

Parameters:
- OVERSAMPLE, 16, number of ticks per bit period. Must be even and ≥ 4.
- DATA_BITS, 8, data bits per frame, sent LSB first. No parity; one stop bit.

Ports:
- clk  input  1  system clock. All logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  oversample tick from the baud generator. One clk cycle wide, at Baud*OVERSAMPLE.
- rxd  input  1  asynchronous serial line; idles high.
- data  output  DATA_BITS  last correctly framed byte.
- data_valid  output  1  one-clk pulse when data updates.
- frame_error  output  1  one-clk pulse when a stop bit is sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Synchroniser:
  - rxd passes through 2 flops to produce rxd_s. All decisions use rxd_s only.
  - On reset both synchroniser flops load 1 (line idle).
- Reset values:
  - state = IDLE; tick counter = 0; bit index = 0; shift register = 0.
  - data = 0, data_valid = 0, frame_error = 0, busy = 0.
- rst wins over every other event, including mid-frame. A partial frame is discarded with no strobe.
- Counting: the tick counter and all sampling advance only on cycles with tick = 1. Cycles with tick = 0 hold all state, except WAIT_IDLE (see below).
- IDLE:
  - On a tick with rxd_s = 0 → START, counter = 0.
- START:
  - Each tick increments the counter.
  - On the tick where the counter = OVERSAMPLE/2 − 1 (the start-bit centre):
    - rxd_s = 0 → DATA, counter = 0, bit index = 0.
    - rxd_s = 1 → glitch rejected; go to IDLE with no output activity.
- DATA:
  - Each tick increments the counter.
  - On the tick where the counter = OVERSAMPLE − 1:
    - Shift rxd_s into the MSB of the shift register (shift right), so the first bit received lands in bit 0 after DATA_BITS shifts.
    - Counter = 0; bit index increments.
  - After the DATA_BITS-th sample → STOP.
- STOP:
  - On the tick where the counter = OVERSAMPLE − 1:
    - rxd_s = 1 → data ← shift register, data_valid = 1 for exactly this one clk, then IDLE.
    - rxd_s = 0 → frame_error = 1 for one clk; data is unchanged and there is no data_valid; then WAIT_IDLE.
- WAIT_IDLE:
  - Re-evaluated every clk, not only on ticks. rxd_s = 1 → IDLE.
  - This prevents a stuck-low line or break from being re-decoded as back-to-back 0x00 frames.
- Strobes:
  - data_valid and frame_error are registered and never high in the same cycle.
  - Both are 0 in all other cycles.
  - data holds its value until the next valid frame.
- Latency: the strobe appears at the clk edge that processes the stop-bit centre tick. That is about 2 clk (synchroniser) + (DATA_BITS + 1.5) × OVERSAMPLE ticks after the falling edge of the start bit.
- Back-to-back frames: after returning to IDLE at the stop-bit centre, a start edge in the next half bit period is accepted. There is no dead time beyond the return to IDLE.
- busy = 1 in START, DATA, STOP and WAIT_IDLE; 0 in IDLE.
- Width rules:
  - Tick counter is clog2(OVERSAMPLE) bits; it wraps only through explicit clears.
  - Bit index is clog2(DATA_BITS + 1) bits.

Test Plan:
- Bench setup for all scenarios: clk 50 MHz, baud generator driving tick every 27 clk (115200 × 16); OVERSAMPLE = 16.
- Reset then frame 0x55 (start 0, bits 1010 1010 LSB first, stop 1) → exactly one data_valid with data = 0x55; frame_error stays 0; busy falls with the strobe.
- Two back-to-back frames 0xA3 then 0x00 with no idle gap → two data_valid pulses with data 0xA3 then 0x00; the pulses are about 10 bit periods (160 ticks) apart.
- Glitch test: rxd low for 4 ticks, then high → FSM returns to IDLE; no data_valid, no frame_error; busy high for under 8 ticks.
- Stop bit forced low on frame 0x3C → frame_error pulses once; data keeps its prior value; busy stays high until rxd returns high; the next good frame 0x81 yields data_valid with 0x81.
- Assert rst for 1 clk in the middle of data bit 4 of frame 0xFF → all outputs return to reset values; no strobe for that frame; the following clean frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: two-flop line synchroniser, start-bit validation at mid-bit,
// centre sampling of each data bit and stop-bit framing check.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          tickCnt_q, tickCnt_d;
  logic [BW-1:0]          bitIdx_q, bitIdx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   rxdMeta_q, rxdSync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rxdMeta_q <= 1'b1;
      rxdSync_q <= 1'b1;
      state_q   <= IDLE;
      tickCnt_q <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rxdMeta_q <= rxd;
      rxdSync_q <= rxdMeta_q;
      state_q   <= state_d;
      tickCnt_q <= tickCnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tickCnt_d = tickCnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tick && !rxdSync_q) begin
          state_d   = START;
          tickCnt_d = '0;
        end
      end

      START: begin
        if (tick) begin
          if (tickCnt_q == HALF_LAST) begin
            tickCnt_d = '0;
            if (!rxdSync_q) begin
              state_d  = DATA;
              bitIdx_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tickCnt_d = tickCnt_q + CW'(1);
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tickCnt_q == FULL_LAST) begin
            shift_d   = {rxdSync_q, shift_q[DATA_BITS-1:1]};
            tickCnt_d = '0;
            bitIdx_d  = bitIdx_q + BW'(1);
            if (bitIdx_q == LAST_BIT) begin
              state_d = STOP;
            end
          end else begin
            tickCnt_d = tickCnt_q + CW'(1);
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (tickCnt_q == FULL_LAST) begin
            tickCnt_d = '0;
            if (rxdSync_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = WAIT_IDLE;
            end
          end else begin
            tickCnt_d = tickCnt_q + CW'(1);
          end
        end
      end

      // Checked every clock so a held-low break is never re-decoded as frames.
      WAIT_IDLE: begin
        if (rxdSync_q) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames are driven on rxd and the
// receiver's strobes are compared with a frame-level expectation queue.
module tb_uart_rx;

  localparam int OS     = 16;
  localparam int DB     = 8;
  localparam int TDIV   = 27;
  localparam int BITCLK = OS * TDIV;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          rxd = 1'b1;
  logic [DB-1:0] data;
  logic          data_valid;
  logic          frame_error;
  logic          busy;

  int total = 0;
  int bad   = 0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .rxd         (rxd),
    .data        (data),
    .data_valid  (data_valid),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  // Baud generator stand-in: one-clock tick every TDIV clocks.
  int tdiv = 0;
  always @(posedge clk) begin
    if (tdiv == TDIV - 1) begin
      tdiv <= 0;
      tick <= 1'b1;
    end else begin
      tdiv <= tdiv + 1;
      tick <= 1'b0;
    end
  end

  typedef struct {
    logic          err;
    logic [DB-1:0] d;
    logic          b;
    int            t;
  } ev_t;

  typedef struct {
    logic          err;
    logic [DB-1:0] d;
  } exp_t;

  ev_t  evQ[$];
  exp_t expQ[$];
  int   evRd = 0;
  int   tickCount = 0;
  int   busyRun = 0;
  int   maxBusyRun = 0;
  int   clrReq = 0;
  int   clrAck = 0;
  bit   bothSeen = 1'b0;

  // Monitor: logs every strobe with the busy level and tick time it occurred at.
  always @(negedge clk) begin
    if (tick) tickCount++;
    if (clrAck != clrReq) begin
      clrAck     = clrReq;
      maxBusyRun = 0;
      busyRun    = 0;
    end
    if (data_valid === 1'b1 || frame_error === 1'b1)
      evQ.push_back('{frame_error === 1'b1, data, busy, tickCount});
    if (data_valid === 1'b1 && frame_error === 1'b1) bothSeen = 1'b1;
    if (busy === 1'b1) begin
      busyRun++;
      if (busyRun > maxBusyRun) maxBusyRun = busyRun;
    end else begin
      busyRun = 0;
    end
  end

  logic [DB-1:0] expData = '0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int clks);
    rxd = v;
    repeat (clks) @(negedge clk);
  endtask

  // Reference model: a good stop bit delivers the byte, a low stop bit
  // reports an error while the last good byte stays on the output.
  task automatic applyStimulus(input logic [DB-1:0] b, input logic stopBit);
    drive(1'b0, BITCLK);
    for (int i = 0; i < DB; i++) drive(b[i], BITCLK);
    drive(stopBit, BITCLK);
    if (stopBit) begin
      expQ.push_back('{1'b0, b});
      expData = b;
    end else begin
      expQ.push_back('{1'b1, expData});
    end
  endtask

  task automatic checkEvents(input string tag);
    int waited = 0;
    int n;
    while ((evQ.size() - evRd) < expQ.size() && waited < 2 * BITCLK) begin
      @(negedge clk);
      waited++;
    end
    repeat (BITCLK) @(negedge clk);
    n = evQ.size() - evRd;
    checkOutput({tag, "_count"}, n, expQ.size());
    for (int i = 0; i < expQ.size() && i < n; i++) begin
      checkOutput({tag, "_err"},  evQ[evRd+i].err, expQ[i].err);
      checkOutput({tag, "_data"}, evQ[evRd+i].d,   expQ[i].d);
      checkOutput({tag, "_busy"}, evQ[evRd+i].b,   expQ[i].err);
    end
    evRd = evQ.size();
    expQ.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_data"},  data,        '0);
    checkOutput({tag, "_valid"}, data_valid,  1'b0);
    checkOutput({tag, "_ferr"},  frame_error, 1'b0);
    checkOutput({tag, "_busy"},  busy,        1'b0);
  endtask

  initial begin
    int idx0;
    int gap;
    logic [DB-1:0] rb;

    rxd = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetState("reset");

    $display("[TB] frame 0x55");
    applyStimulus(8'h55, 1'b1);
    drive(1'b1, BITCLK);
    checkEvents("f55");

    $display("[TB] back-to-back 0xA3, 0x00");
    idx0 = evQ.size();
    applyStimulus(8'hA3, 1'b1);
    applyStimulus(8'h00, 1'b1);
    drive(1'b1, BITCLK);
    checkEvents("b2b");
    gap = (evQ.size() >= idx0 + 2) ? (evQ[idx0+1].t - evQ[idx0].t) : 0;
    checkOutput("b2b_gap_ticks", (gap >= 159 && gap <= 161), 1'b1);

    $display("[TB] start glitch");
    clrReq++;
    drive(1'b0, 4 * TDIV);
    drive(1'b1, 2 * BITCLK);
    checkEvents("glitch");
    checkOutput("glitch_busy_seen", (maxBusyRun > 0), 1'b1);
    checkOutput("glitch_busy_short", (maxBusyRun <= 8 * TDIV), 1'b1);

    $display("[TB] stop bit low on 0x3C, then break");
    applyStimulus(8'h3C, 1'b0);
    drive(1'b0, 3 * BITCLK);
    checkOutput("break_busy", busy, 1'b1);
    checkEvents("ferr");
    checkOutput("ferr_data_kept", data, expData);
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("break_release_busy", busy, 1'b0);
    applyStimulus(8'h81, 1'b1);
    drive(1'b1, BITCLK);
    checkEvents("f81");

    $display("[TB] reset during data bit 4 of 0xFF");
    drive(1'b0, BITCLK);
    for (int i = 0; i < 4; i++) drive(1'b1, BITCLK);
    drive(1'b1, BITCLK / 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetState("midrst");
    expData = '0;
    drive(1'b1, BITCLK / 2 + 4 * BITCLK);
    checkEvents("midrst_frame");
    applyStimulus(8'h12, 1'b1);
    drive(1'b1, BITCLK);
    checkEvents("f12");

    $display("[TB] random frames");
    for (int k = 0; k < 4; k++) begin
      rb = DB'($urandom_range(0, 255));
      applyStimulus(rb, 1'b1);
      drive(1'b1, int'($urandom_range(0, 1)) * BITCLK + 1);
    end
    drive(1'b1, BITCLK);
    checkEvents("rand");

    checkOutput("strobes_exclusive", bothSeen, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
